gpio_hex_tx: RTL



---
 rtl/gpio_hex_tx.sv | 125 ++++++++++++
 1 files changed

// File: rtl/gpio_hex_tx.sv
// rtl/gpio_hex_tx.sv - seven-segment transmitter driving a 16-bit value onto the GPIO header
module gpio_hex_tx #(
  parameter int SETTLE_CYCLES  = 4,
  parameter bit ACTIVE_LOW_SEG = 1'b1
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        load,
  input  logic [15:0] data,
  output logic        busy,
  inout  wire  [31:0] GPIO
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              oe_q, oe_d;
  logic              tog_q, tog_d;
  logic [1:0]        lane_q, lane_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       data_q, data_d;
  logic [3:0][6:0]   seg_q, seg_d;

  logic [1:0]        lane_nx;
  logic [3:0]        nib_nx;

  function automatic logic [6:0] enc(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return ACTIVE_LOW_SEG ? s : ~s;
  endfunction

  assign lane_nx = lane_q + 2'd1;
  assign nib_nx  = data_q[{lane_nx, 2'b00} +: 4];

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    oe_d    = oe_q;
    tog_d   = tog_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    seg_d   = seg_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          data_d   = data;
          busy_d   = 1'b1;
          oe_d     = 1'b1;
          seg_d[0] = enc(data[3:0]);
          lane_d   = 2'd0;
          cnt_d    = '0;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q < CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else if (lane_q != 2'd3) begin
          lane_d         = lane_nx;
          cnt_d          = '0;
          seg_d[lane_nx] = enc(nib_nx);
        end else begin
          // Frame complete: flip the marker so the far end sees new data.
          tog_d   = ~tog_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      oe_q    <= 1'b0;
      tog_q   <= 1'b0;
      lane_q  <= 2'd0;
      cnt_q   <= '0;
      data_q  <= 16'h0000;
      seg_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      oe_q    <= oe_d;
      tog_q   <= tog_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      seg_q   <= seg_d;
    end
  end

  assign busy = busy_q;
  assign GPIO = oe_q ? {tog_q, seg_q[3], 1'b0, seg_q[2], 1'b0, seg_q[1], 1'b0, seg_q[0]}
                     : 32'hzzzz_zzzz;

endmodule
